stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Front-end controller for the BCD seconds counter in the stopwatch design. It debounces three active-low pushbuttons: start/stop, clear and lap. A four-state run/pause/lap machine drives the counter with a one-cycle count-enable pulse and a one-cycle clear pulse. It also owns the display path, showing either the live counter digits or a frozen lap snapshot.

## Interface
- TICK_DIV, default 50_000_000: clk cycles per count-enable pulse (1 Hz at 50 MHz); minimum 2.
- DEB_CYCLES, default 1_000_000: consecutive stable cycles needed to accept a key level; minimum 1.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_ss  in  1  raw start/stop button, active-low, asynchronous to clk.
- key_clr  in  1  raw clear button, active-low, asynchronous to clk.
- key_lap  in  1  raw lap button, active-low, asynchronous to clk.
- sec_l  in  4  live seconds units digit (BCD) from the counter.
- sec_h  in  4  live seconds tens digit (BCD) from the counter.
- cnt_en  out  1  one-cycle pulse: advance the counter by one second.
- cnt_clr  out  1  one-cycle pulse: zero the counter.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP.
- disp_l  out  4  registered display units digit.
- disp_h  out  4  registered display tens digit.

## Operation
- Key path, per key:
  - 2-FF synchronizer.
  - Stability counter: a synchronized level differing from the debounced level for DEB_CYCLES consecutive cycles replaces it; any bounce restarts the count.
  - Press event = one-cycle pulse on a debounced 1->0 transition. Release produces no event.
- Event priority, at most one event acted on per cycle: clr > ss > lap. Lower-priority events in the same cycle are discarded.
- States IDLE, RUN, PAUSE, LAP. Transitions:
  - IDLE: ss -> RUN. clr -> IDLE with cnt_clr pulse. lap ignored.
  - RUN: ss -> PAUSE. lap -> LAP, capturing sec_h/sec_l into the lap latch. clr ignored.
  - LAP: lap -> RUN (display goes live). ss -> PAUSE (display goes live). clr ignored.
  - PAUSE: ss -> RUN. clr -> IDLE with cnt_clr pulse. lap ignored.
- Prescaler, 0..TICK_DIV-1:
  - RUN or LAP: increments every cycle. At TICK_DIV-1, cnt_en pulses for one cycle and the prescaler wraps to 0.
  - PAUSE: holds its value, so a resume completes the partial second.
  - IDLE: forced to 0.
  - A cnt_clr pulse zeroes it.
- cnt_en never asserts outside RUN/LAP, and never in the same cycle as cnt_clr.
- Display: each cycle disp_{h,l} <= lap_active ? latch : sec_{h,l}. The latch is loaded only on the RUN->LAP transition.
- The controller applies no BCD arithmetic. Digit range and wrap belong to the counter.

## Timing
- Reset values:
  - State IDLE.
  - cnt_en=0, cnt_clr=0, running=0, lap_active=0, disp_l=0, disp_h=0.
  - Prescaler 0, lap latch 0.
  - Synchronizers and debounced levels 1 (released); stability counters 0.
- Reset is asynchronous mid-operation. Every register returns to its reset value immediately; no event, pulse or partial second survives.
- Key latency:
  - Raw key low at edge t, stable from then on: press event high in cycle t+2+DEB_CYCLES.
  - State, running, lap_active, cnt_clr and the latch update on the next edge, t+3+DEB_CYCLES.
- First cnt_en after IDLE->RUN occurs TICK_DIV cycles after the state change, then every TICK_DIV cycles.
- ss event in the same cycle as prescaler = TICK_DIV-1 while in RUN: that cnt_en is still emitted, then the state becomes PAUSE with the prescaler at 0.
- cnt_clr is high for exactly one cycle per accepted clear, registered and aligned with the state update.
- disp lags sec inputs by one cycle when live.
- disp reflects the latch from the cycle lap_active rises. It returns to live one cycle after lap_active falls.

## Test plan
Bench parameters: TICK_DIV=10, DEB_CYCLES=4.

- Reset then idle for 50 cycles -> all outputs 0, state IDLE, no cnt_en.
- Clean key_ss press held 20 cycles -> running rises 7 cycles after the falling edge. cnt_en pulses every 10 cycles thereafter: first pulse 10 cycles after running rises.
- key_ss bouncing 1-0-1-0 at 2-cycle spacing, then stable low -> exactly one event, timed 7 cycles after the final falling edge. Release bounce produces no event.
- Running with the prescaler at 6, press ss (PAUSE), wait 100 cycles, press ss (RUN) -> no cnt_en during PAUSE. First cnt_en after resume arrives 4 cycles after the state change (prescaler was at 6).
- Running with sec_h/sec_l = 2/7, press lap -> disp holds 2/7 while the counter keeps receiving cnt_en. Second lap press -> disp follows sec inputs with 1-cycle lag.
- In PAUSE, press key_clr and key_ss in the same cycle -> cnt_clr single pulse, state IDLE, running stays 0. Then assert reset mid-RUN -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Front-end controller for the stopwatch's BCD seconds counter.
// Debounces three active-low pushbuttons (start/stop, clear, lap), runs the
// IDLE/RUN/PAUSE/LAP machine, generates the one-second count-enable and the
// clear pulse for the counter, and drives the display with either the live
// counter digits or a frozen lap snapshot.
//
// Parameters:
//   TICK_DIV    clk cycles per cnt_en pulse (>= 2)
//   DEB_CYCLES  consecutive stable cycles needed to accept a key level (>= 1)
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous reset, active low
//   key_ss/clr/lap      raw active-low buttons, asynchronous to clk
//   sec_l, sec_h        live BCD digits from the counter
//   cnt_en              one-cycle pulse: advance the counter by one second
//   cnt_clr             one-cycle pulse: zero the counter
//   running             high in RUN and LAP
//   lap_active          high in LAP
//   disp_l, disp_h      registered display digits
module stopwatch_ctrl #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_ss,
   input  logic       key_clr,
   input  logic       key_lap,
   input  logic [3:0] sec_l,
   input  logic [3:0] sec_h,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       running,
   output logic       lap_active,
   output logic [3:0] disp_l,
   output logic [3:0] disp_h
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [2:0]    key_raw;
   logic [2:0]    press;
   logic          ev_clr;
   logic          ev_ss;
   logic          ev_lap;
   logic          do_clr;
   logic          do_capture;
   logic          counting;
   logic [PW-1:0] presc;
   logic [7:0]    lap_latch;

   // Bit order of the key vector: 0 = start/stop, 1 = clear, 2 = lap.
   assign key_raw = {key_lap, key_clr, key_ss};

   // Per-key synchronizer, stability counter and press detector. The
   // debounced level only follows the synchronized level after it has
   // disagreed for DEB_CYCLES edges in a row; any agreeing sample restarts
   // the count. The press pulse is registered once more after the debounced
   // falling edge so the FSM sees it one cycle after the level settles.
   genvar g;
   for (g = 0; g < 3; g++) begin : g_key
      logic          sync_a;
      logic          sync_b;
      logic          deb;
      logic          deb_d;
      logic          evt;
      logic [CW-1:0] stab_cnt;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync_a   <= 1'b1;
            sync_b   <= 1'b1;
            deb      <= 1'b1;
            deb_d    <= 1'b1;
            evt      <= 1'b0;
            stab_cnt <= '0;
         end else begin
            sync_a <= key_raw[g];
            sync_b <= sync_a;
            deb_d  <= deb;
            evt    <= deb_d & ~deb;
            if (sync_b == deb) begin
               stab_cnt <= '0;
            end else if (stab_cnt == DEB_LAST) begin
               deb      <= sync_b;
               stab_cnt <= '0;
            end else begin
               stab_cnt <= stab_cnt + CW'(1);
            end
         end
      end

      assign press[g] = evt;
   end

   // Only the highest-priority event is acted on; lower ones are dropped
   // even when the winning event is ignored in the current state.
   assign ev_clr = press[1];
   assign ev_ss  = press[0] & ~press[1];
   assign ev_lap = press[2] & ~press[1] & ~press[0];

   assign counting   = (state == RUN) || (state == LAP);
   assign running    = counting;
   assign lap_active = (state == LAP);

   // Next-state logic plus the clear and lap-capture strobes.
   always_comb begin
      next_state = state;
      do_clr     = 1'b0;
      do_capture = 1'b0;
      case (state)
         IDLE: begin
            if (ev_clr) begin
               do_clr = 1'b1;
            end else if (ev_ss) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (ev_ss) begin
               next_state = PAUSE;
            end else if (ev_lap) begin
               next_state = LAP;
               do_capture = 1'b1;
            end
         end
         LAP: begin
            if (ev_ss) begin
               next_state = PAUSE;
            end else if (ev_lap) begin
               next_state = RUN;
            end
         end
         PAUSE: begin
            if (ev_clr) begin
               next_state = IDLE;
               do_clr     = 1'b1;
            end else if (ev_ss) begin
               next_state = RUN;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register, registered clear pulse and lap latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt_clr   <= 1'b0;
         lap_latch <= '0;
      end else begin
         state   <= next_state;
         cnt_clr <= do_clr;
         if (do_capture) begin
            lap_latch <= {sec_h, sec_l};
         end
      end
   end

   // Prescaler acts on the current state, so a pause holds the partial
   // second and the tick already due in the pausing cycle is still emitted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc  <= '0;
         cnt_en <= 1'b0;
      end else begin
         cnt_en <= counting && (presc == TICK_LAST);
         if (do_clr || (state == IDLE)) begin
            presc <= '0;
         end else if (counting) begin
            if (presc == TICK_LAST) begin
               presc <= '0;
            end else begin
               presc <= presc + PW'(1);
            end
         end
      end
   end

   // Display register: the lap snapshot equals the digits captured on entry,
   // so the switch to the latch is seamless on the cycle LAP begins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_h <= '0;
         disp_l <= '0;
      end else if (lap_active) begin
         disp_h <= lap_latch[7:4];
         disp_l <= lap_latch[3:0];
      end else begin
         disp_h <= sec_h;
         disp_l <= sec_l;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DEB_CYCLES=4.
// A behavioural model (window-based debounce, priority event pick, run/pause
// state and a modulo prescaler) predicts every output each cycle; a compare
// process checks the DUT against it on every falling clock edge, and the
// main sequence adds hand-computed latency and value checks.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

   localparam int TD = 10;
   localparam int DB = 4;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_LAP   = 3;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       key_ss  = 1'b1;
   logic       key_clr = 1'b1;
   logic       key_lap = 1'b1;
   logic [3:0] sec_l   = 4'd0;
   logic [3:0] sec_h   = 4'd0;
   logic       cnt_en;
   logic       cnt_clr;
   logic       running;
   logic       lap_active;
   logic [3:0] disp_l;
   logic [3:0] disp_h;

   int cyc    = 0;
   int checks = 0;
   int passes = 0;

   stopwatch_ctrl #(
      .TICK_DIV   (TD),
      .DEB_CYCLES (DB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_ss     (key_ss),
      .key_clr    (key_clr),
      .key_lap    (key_lap),
      .sec_l      (sec_l),
      .sec_h      (sec_h),
      .cnt_en     (cnt_en),
      .cnt_clr    (cnt_clr),
      .running    (running),
      .lap_active (lap_active),
      .disp_l     (disp_l),
      .disp_h     (disp_h)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge N, cyc == N.
   always @(posedge clk) cyc <= cyc + 1;

   // Model state.
   int         m_state;
   int         m_presc;
   logic [7:0] m_latch;
   logic [7:0] m_disp;
   bit         m_ce;
   bit         m_clr;
   bit [2:0]   m_deb;
   bit [2:0]   m_pend;
   bit [2:0]   m_evt;
   bit [2:0]   m_hist [DB+1];

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
   endtask

   task automatic modelReset();
      m_state = M_IDLE;
      m_presc = 0;
      m_latch = 8'h00;
      m_disp  = 8'h00;
      m_ce    = 1'b0;
      m_clr   = 1'b0;
      m_deb   = 3'b111;
      m_pend  = 3'b000;
      m_evt   = 3'b000;
      for (int j = 0; j <= DB; j++) m_hist[j] = 3'b111;
   endtask

   // One clock edge of the model. m_hist[j] holds the raw sample taken
   // j+1 edges ago; the synchronizer delay means samples 2..DB+1 edges old
   // form the debounce window for this edge.
   task automatic modelStep();
      bit [2:0] fell;
      bit       differs;
      bit       counting;
      bit       clr_now;
      bit       cap;
      int       nxt;
      fell = 3'b000;
      for (int k = 0; k < 3; k++) begin
         differs = 1'b1;
         for (int j = 1; j <= DB; j++) begin
            if (m_hist[j][k] == m_deb[k]) differs = 1'b0;
         end
         if (differs) begin
            fell[k]  = m_deb[k];
            m_deb[k] = ~m_deb[k];
         end
      end
      nxt     = m_state;
      clr_now = 1'b0;
      cap     = 1'b0;
      if (m_evt[1]) begin
         if (m_state == M_IDLE || m_state == M_PAUSE) begin
            nxt     = M_IDLE;
            clr_now = 1'b1;
         end
      end else if (m_evt[0]) begin
         if (m_state == M_IDLE || m_state == M_PAUSE) nxt = M_RUN;
         else nxt = M_PAUSE;
      end else if (m_evt[2]) begin
         if (m_state == M_RUN) begin
            nxt = M_LAP;
            cap = 1'b1;
         end else if (m_state == M_LAP) begin
            nxt = M_RUN;
         end
      end
      counting = (m_state == M_RUN) || (m_state == M_LAP);
      m_ce  = counting && (m_presc == TD - 1);
      m_clr = clr_now;
      m_disp = (m_state == M_LAP) ? m_latch : {sec_h, sec_l};
      if (cap) m_latch = {sec_h, sec_l};
      if (clr_now || m_state == M_IDLE) m_presc = 0;
      else if (counting) m_presc = (m_presc + 1) % TD;
      m_state = nxt;
      m_evt   = m_pend;
      m_pend  = fell;
      for (int j = DB; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = {key_lap, key_clr, key_ss};
   endtask

   initial begin
      modelReset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) modelReset();
         else modelStep();
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      logic [11:0] exp_v;
      forever begin
         @(negedge clk);
         exp_v = {m_ce, m_clr, (m_state == M_RUN) || (m_state == M_LAP),
                  m_state == M_LAP, m_disp};
         checkOutput("model", {cnt_en, cnt_clr, running, lap_active, disp_h, disp_l}, exp_v);
      end
   end

   // Drive the keys (optionally after the next posedge); t is the edge that
   // first samples the new levels.
   task automatic applyStimulus(input bit sync_edge, input bit ss, input bit clr,
                                input bit lap, output int t);
      if (sync_edge) begin
         @(posedge clk);
         #1;
      end
      key_ss  = ss;
      key_clr = clr;
      key_lap = lap;
      t = cyc + 1;
   endtask

   // Bounded wait for an output condition; at = edge index that produced it.
   task automatic waitFor(input int sel, input int limit, output int at);
      bit hit;
      at = -1;
      for (int i = 0; i < limit && at < 0; i++) begin
         @(negedge clk);
         case (sel)
            0:       hit = running;
            1:       hit = !running;
            2:       hit = cnt_en;
            3:       hit = lap_active;
            4:       hit = !lap_active;
            5:       hit = cnt_clr;
            default: hit = 1'b0;
         endcase
         if (hit) at = cyc;
      end
      if (at < 0) checkOutput($sformatf("timeout_sel%0d", sel), 0, 1);
   endtask

   task automatic observe(input int n, output int n_ce, output int n_run, output int n_clr);
      n_ce  = 0;
      n_run = 0;
      n_clr = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (cnt_en) n_ce++;
         if (running) n_run++;
         if (cnt_clr) n_clr++;
      end
   endtask

   task automatic releaseKeys();
      int t;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, t);
      repeat (10) @(posedge clk);
   endtask

   task automatic waitPresc(input int val);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (m_state == M_RUN && m_presc == val) ok = 1'b1;
      end
      if (!ok) checkOutput("presc_sync", 0, 1);
   endtask

   initial begin
      int t, e, c, c2, r, f;
      int n_ce, n_run, n_clr, bad;
      logic [7:0] prev;
      bit bounce_pat [5];
      bit release_pat [5];

      #2 reset = 1'b0;
      #1 checkOutput("reset_outputs", {cnt_en, cnt_clr, running, lap_active, disp_h, disp_l}, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Idle after reset.
      observe(50, n_ce, n_run, n_clr);
      checkOutput("idle_cnt_en", n_ce, 0);
      checkOutput("idle_running", n_run, 0);
      checkOutput("idle_cnt_clr", n_clr, 0);

      // Clean start press.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, t);
      waitFor(0, 20, e);
      checkOutput("ss_latency", e - t, 7);
      waitFor(2, 20, c);
      checkOutput("first_cnt_en", c - e, 10);
      waitFor(2, 20, c2);
      checkOutput("cnt_en_period", c2 - c, 10);
      releaseKeys();

      // Bouncing press pauses exactly once, timed from the final fall.
      bounce_pat  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      release_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, bounce_pat[i], 1'b1, 1'b1, t);
         if (i < 4) @(posedge clk);
      end
      waitFor(1, 20, e);
      checkOutput("bounce_latency", e - t, 7);
      repeat (10) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, release_pat[i], 1'b1, 1'b1, t);
         if (i < 4) @(posedge clk);
      end
      observe(30, n_ce, n_run, n_clr);
      checkOutput("release_no_event", n_run, 0);

      // Resume, then pause with the prescaler holding 6.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, t);
      waitFor(0, 20, e);
      releaseKeys();
      waitPresc(8);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, t);
      waitFor(1, 20, e);
      checkOutput("pause_latency", e - t, 7);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, t);
      observe(100, n_ce, n_run, n_clr);
      checkOutput("pause_no_cnt_en", n_ce, 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, t);
      waitFor(0, 20, r);
      waitFor(2, 20, c);
      checkOutput("resume_partial_second", c - r, 4);
      releaseKeys();

      // Start/stop landing on the wrap cycle: tick still emitted.
      waitPresc(2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, t);
      waitFor(1, 20, e);
      checkOutput("wrap_tick_kept", cnt_en, 1);
      releaseKeys();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, t);
      waitFor(0, 20, r);
      waitFor(2, 20, c);
      checkOutput("wrap_resume_full_second", c - r, 10);
      releaseKeys();

      // Lap snapshot of 2/7.
      @(posedge clk);
      #1;
      sec_h = 4'd2;
      sec_l = 4'd7;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, t);
      waitFor(3, 20, e);
      checkOutput("lap_latency", e - t, 7);
      checkOutput("lap_capture_disp", {disp_h, disp_l}, 8'h27);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, t);
      bad  = 0;
      n_ce = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         sec_l = 4'(cyc % 10);
         sec_h = 4'((cyc / 10) % 6);
         @(negedge clk);
         if ({disp_h, disp_l} != 8'h27) bad++;
         if (cnt_en) n_ce++;
      end
      checkOutput("lap_frozen", bad, 0);
      checkOutput("lap_cnt_en_count", n_ce, 4);

      // Second lap press returns the display to live with one-cycle lag.
      f = -1;
      t = 0;
      for (int i = 0; i < 60 && !(f >= 0 && cyc >= f + 5); i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin
            key_lap = 1'b0;
            t = cyc + 1;
         end
         if (i == 12) key_lap = 1'b1;
         prev  = {sec_h, sec_l};
         sec_l = 4'(cyc % 10);
         sec_h = 4'((cyc / 10) % 6);
         @(negedge clk);
         if (f < 0 && !lap_active) begin
            f = cyc;
            checkOutput("lap_exit_latency", f - t, 7);
            checkOutput("lap_exit_disp_latch", {disp_h, disp_l}, 8'h27);
         end else if (f >= 0) begin
            checkOutput("live_lag", {disp_h, disp_l}, prev);
         end
      end
      if (f < 0) checkOutput("lap_exit_timeout", 0, 1);
      key_lap = 1'b1;
      repeat (10) @(posedge clk);

      // Pause, then clear and start/stop together: clear wins.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, t);
      waitFor(1, 20, e);
      releaseKeys();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, t);
      waitFor(5, 20, c);
      checkOutput("clr_latency", c - t, 7);
      checkOutput("clr_running", running, 0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, t);
      observe(30, n_ce, n_run, n_clr);
      checkOutput("clr_single_pulse", n_clr, 0);
      checkOutput("clr_stays_stopped", n_run, 0);

      // Start again, then reset asynchronously mid-run.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, t);
      waitFor(0, 20, e);
      releaseKeys();
      @(posedge clk);
      #2 checkOutput("pre_reset_running", running, 1);
      #1 reset = 1'b0;
      #1 checkOutput("async_reset_outputs",
                     {cnt_en, cnt_clr, running, lap_active, disp_h, disp_l}, 0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      observe(20, n_ce, n_run, n_clr);
      checkOutput("post_reset_idle_run", n_run, 0);
      checkOutput("post_reset_idle_ce", n_ce, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
